// File: rtl/regfile_dump_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_dump_if - valid/ready beat stream out of regfile_dump. Rev 1.0 |
// +--------------------------------------------------------------------+
interface regfile_dump_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic [11:0]           m_addr;
   logic                  m_last;

   modport master (
      output m_valid,
      output m_data,
      output m_addr,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      input  m_addr,
      input  m_last,
      output m_ready
   );
endinterface
`default_nettype wire

// File: rtl/regfile_dump.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_dump - streams a register-file address window as tagged beats.     |
// | Optional feature macro: DUMP_ADDR_CHECK_EN (echoed-address check).  Rev 1.0 |
// +--------------------------------------------------------------------------+
module regfile_dump #(
   parameter int DATA_WIDTH = 8
) (
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   input  wire logic                  i_start,
   input  wire logic [11:0]           i_base_addr,
   input  wire logic [12:0]           i_count,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_err,
   output logic                       o_ran_re,
   output logic [11:0]                o_ran_r_addr,
   input  wire logic [DATA_WIDTH-1:0] i_ran_r_data,
   input  wire logic [11:0]           i_out_ran_r_addr,
   regfile_dump_if.master             m_if
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [11:0]           r_rd_ptr;
   logic [12:0]           r_remaining;
   logic                  r_armed;
   logic                  r_m_valid;
   logic [DATA_WIDTH-1:0] r_m_data;
   logic [11:0]           r_m_addr;
   logic                  r_m_last;
   logic                  w_start_acc;
   logic                  w_issue;
   logic                  w_addr_ok;
   logic                  w_load;

   assign w_start_acc = (r_state == S_IDLE) && i_start;
   // r_armed holds off the first issue until the cycle after READ is entered
   assign w_issue     = (r_state == S_READ) && r_armed && (r_remaining != 13'd0) &&
                        (!r_m_valid || m_if.m_ready);
   assign w_load      = w_issue && w_addr_ok;

`ifdef DUMP_ADDR_CHECK_EN
   logic r_err;

   // Case-equality so a floating echo (no data behind the address) is a miss
   assign w_addr_ok = (i_out_ran_r_addr === r_rd_ptr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_start_acc) begin
         r_err <= 1'b0;
      end else if (w_issue && !w_addr_ok) begin
         r_err <= 1'b1;
      end
   end

   assign o_err = r_err;
`else
   logic w_unused_echo;

   assign w_unused_echo = &{1'b0, i_out_ran_r_addr};
   assign w_addr_ok     = 1'b1;
   assign o_err         = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start_acc) begin
               w_next = (i_count == 13'd0) ? S_FLUSH : S_READ;
            end
         end
         S_READ: begin
            if (w_issue && !w_addr_ok) begin
               w_next = S_FLUSH;
            end else if (w_issue && (r_remaining == 13'd1)) begin
               w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (r_m_valid && m_if.m_ready && r_m_last) begin
               w_next = S_FLUSH;
            end
         end
         S_FLUSH: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed     <= 1'b0;
         r_rd_ptr    <= 12'd0;
         r_remaining <= 13'd0;
         r_m_valid   <= 1'b0;
         r_m_data    <= '0;
         r_m_addr    <= 12'd0;
         r_m_last    <= 1'b0;
      end else begin
         r_armed <= (r_state == S_READ);
         if (w_start_acc) begin
            r_rd_ptr    <= i_base_addr;
            r_remaining <= i_count;
         end else if (w_issue) begin
            r_rd_ptr    <= r_rd_ptr + 12'd1;
            r_remaining <= r_remaining - 13'd1;
         end
         if (w_load) begin
            r_m_valid <= 1'b1;
            r_m_data  <= i_ran_r_data;
            r_m_addr  <= r_rd_ptr;
            r_m_last  <= (r_remaining == 13'd1);
         end else if (m_if.m_ready) begin
            r_m_valid <= 1'b0;
         end
      end
   end

   assign o_busy       = (r_state != S_IDLE);
   assign o_done       = (r_state == S_FLUSH);
   assign o_ran_re     = w_issue;
   assign o_ran_r_addr = w_issue ? r_rd_ptr : 12'd0;

   assign m_if.m_valid = r_m_valid;
   assign m_if.m_data  = r_m_data;
   assign m_if.m_addr  = r_m_addr;
   assign m_if.m_last  = r_m_last;

endmodule
`default_nettype wire
